pkt_hdr_deparser: RTL and testbench
===================================

Name: pkt_hdr_deparser

Overview:
- Consumer end of the parser→stage→PHV-FIFO path.
- Pairs each processed PHV with its buffered packet, writes the PHV header bytes back over the packet's first beat, and replaces first-beat tuser with PHV metadata.
- Drops the packet when the PHV discard flag is set.
- Drives the master AXI Stream out of the processing block.

Parameters:
- C_S_AXIS_DATA_WIDTH, 256, packet data width.
- C_S_AXIS_TUSER_WIDTH, 128, tuser width.
- PHV_WIDTH, 1124, packet header vector width.
- HDR_BYTES, 32, header bytes written back; must be ≤ C_S_AXIS_DATA_WIDTH/8.
- DISCARD_BIT, 128, PHV bit index of the discard flag.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- pkt_fifo_tdata  in  256  packet FIFO head data (fallthrough).
- pkt_fifo_tkeep  in  32  packet FIFO head keep.
- pkt_fifo_tuser  in  128  packet FIFO head tuser.
- pkt_fifo_tlast  in  1  packet FIFO head last.
- pkt_fifo_empty  in  1  packet FIFO empty.
- pkt_fifo_rd_en  out  1  pop packet FIFO.
- phv_fifo_out  in  PHV_WIDTH  PHV FIFO head (fallthrough).
- phv_fifo_empty  in  1  PHV FIFO empty.
- phv_fifo_rd_en  out  1  pop PHV FIFO.
- m_axis_tdata  out  256  output data.
- m_axis_tkeep  out  32  output keep.
- m_axis_tuser  out  128  output tuser.
- m_axis_tvalid  out  1  output valid.
- m_axis_tlast  out  1  output last.
- m_axis_tready  in  1  downstream ready.

Behaviour:
- Reset (synchronous, active-high on clk): state=IDLE; all m_axis_* = 0; both rd_en = 0.
- Reset asserted mid-packet: abandon the packet, no FIFO pops that cycle, m_axis_tvalid=0 next cycle.
- Output register: single-entry registered m_axis_*.
  - It is "free" when !m_axis_tvalid || m_axis_tready.
  - Data is held stable while m_axis_tvalid && !m_axis_tready.
- Beats are consumed only when the output is free. DROP beats do not need the output to be free.
- Latency: one cycle from FIFO head available to m_axis_tvalid.
- IDLE:
  - Waits for !pkt_fifo_empty && !phv_fifo_empty. Either FIFO alone empty: no pops, no output.
  - If phv[DISCARD_BIT]=1: pop the first beat and the PHV. Go to DROP, or stay IDLE if that beat has tlast.
  - Else, when the output is free:
    - Load the first beat with tdata[HDR_BYTES*8-1:0] = phv[PHV_WIDTH-1 -: HDR_BYTES*8] and tuser = phv[127:0].
    - Pass the upper tdata bytes, tkeep and tlast through unchanged.
    - Pop both FIFOs (one-cycle pulses).
    - Go to BODY if !tlast, else stay IDLE.
- BODY: when the output is free and !pkt_fifo_empty, pass the beat through unmodified (tuser included) and pop it. On tlast → IDLE.
- DROP: pop one beat per cycle while !pkt_fifo_empty. m_axis_tvalid stays 0 for dropped beats. On tlast → IDLE.
- Back-to-back: tlast beat accepted and next packet's first beat loaded in consecutive cycles; no idle bubble when both FIFOs are non-empty.
- Simultaneous output accept (tvalid&&tready) and new load: the new beat replaces the old one in the same cycle.
- phv_fifo_rd_en asserts at most once per packet, only on a first beat.
- pkt_fifo_rd_en is never asserted while pkt_fifo_empty.

Optional Feature:
- Macro DEPAR_STATS_EN.
- When defined, adds two output ports:
  - pkt_out_cnt  out  32: +1 per accepted tlast beat that is not dropped.
  - pkt_drop_cnt  out  32: +1 per dropped packet, counted at the first-beat pop.
- Both counters wrap at 2^32 and reset to 0.
- When undefined: ports and logic are absent; core behaviour is identical.

Decomposition:
- Package depar_pkg holds:
  - PHV_WIDTH, HDR_BYTES, DISCARD_BIT, the metadata slice bounds.
  - State enum {IDLE, BODY, DROP}.
- One natural sub-module: depar_out_reg, the single-entry AXIS output register with the free/hold logic.

Test Plan:
- Single-beat packet: tdata=all 0xAA, tlast=1; PHV header bytes=0x11..; phv[127:0]=0x5; tready=1 → one beat out a cycle later:
  - low 32 bytes = PHV bytes, tuser=0x5, tlast=1.
  - Each FIFO pops exactly once.
- 3-beat packet with tready toggling 1,0,0,1,… → 3 beats out in order, each held stable while tready=0. Beats 2–3 keep their original tuser.
- phv[128]=1 on a 4-beat packet → 4 pkt pops, 1 PHV pop, zero m_axis_tvalid cycles. With DEPAR_STATS_EN: pkt_drop_cnt=1.
- PHV FIFO empty for 10 cycles while pkt FIFO holds a packet → no pops, no output. Output begins one cycle after the PHV arrives.
- Two 2-beat packets queued back-to-back, tready=1 → 4 consecutive valid beats with no gap.
- Reset during beat 2 of a 3-beat packet → m_axis_tvalid=0 next cycle and state IDLE. The following packet emits correctly.

Source files
------------

// File: rtl/depar_pkg.sv
// Shared constants and state encoding for the packet header deparser.
package depar_pkg;

    localparam int DATA_WIDTH  = 256;
    localparam int TUSER_WIDTH = 128;
    localparam int PHV_WIDTH   = 1124;
    localparam int HDR_BYTES   = 32;
    localparam int DISCARD_BIT = 128;

    // PHV bits that replace first-beat tuser
    localparam int META_LO = 0;
    localparam int META_HI = 127;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BODY = 2'd1,
        DROP = 2'd2
    } depar_state_e;

endpackage

// File: rtl/depar_out_reg.sv
// Single-entry registered AXI Stream output stage. The slot is free when it
// is empty or its current beat is being accepted this cycle; a load in that
// same cycle replaces the departing beat.
module depar_out_reg #(
    parameter int DATA_W = 256,
    parameter int USER_W = 128
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_i,
    input  logic [DATA_W-1:0]   tdata_i,
    input  logic [DATA_W/8-1:0] tkeep_i,
    input  logic [USER_W-1:0]   tuser_i,
    input  logic                tlast_i,
    input  logic                tready_i,
    output logic                free_o,
    output logic [DATA_W-1:0]   tdata_o,
    output logic [DATA_W/8-1:0] tkeep_o,
    output logic [USER_W-1:0]   tuser_o,
    output logic                tvalid_o,
    output logic                tlast_o
);

    logic [DATA_W-1:0]   tdata_q,  tdata_d;
    logic [DATA_W/8-1:0] tkeep_q,  tkeep_d;
    logic [USER_W-1:0]   tuser_q,  tuser_d;
    logic                tvalid_q, tvalid_d;
    logic                tlast_q,  tlast_d;

    assign free_o = !tvalid_q || tready_i;

    // Next-state of the slot: load, drain on accept, or hold while stalled
    always_comb begin
        tdata_d  = tdata_q;
        tkeep_d  = tkeep_q;
        tuser_d  = tuser_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        if (load_i) begin
            tdata_d  = tdata_i;
            tkeep_d  = tkeep_i;
            tuser_d  = tuser_i;
            tlast_d  = tlast_i;
            tvalid_d = 1'b1;
        end else if (tready_i) begin
            tvalid_d = 1'b0;
        end else begin
            tvalid_d = tvalid_q;
        end
    end

    // Slot register with synchronous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tuser_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            tdata_q  <= tdata_d;
            tkeep_q  <= tkeep_d;
            tuser_q  <= tuser_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
        end
    end

    assign tdata_o  = tdata_q;
    assign tkeep_o  = tkeep_q;
    assign tuser_o  = tuser_q;
    assign tvalid_o = tvalid_q;
    assign tlast_o  = tlast_q;

endmodule

// File: rtl/pkt_hdr_deparser.sv
// Packet header deparser: pairs each PHV with its buffered packet, writes the
// PHV header bytes over the first beat, swaps first-beat tuser for PHV
// metadata, and drops packets whose PHV discard flag is set.
// Optional build macro DEPAR_STATS_EN adds pkt_out_cnt / pkt_drop_cnt.
module pkt_hdr_deparser #(
    parameter int C_S_AXIS_DATA_WIDTH  = depar_pkg::DATA_WIDTH,
    parameter int C_S_AXIS_TUSER_WIDTH = depar_pkg::TUSER_WIDTH,
    parameter int PHV_WIDTH            = depar_pkg::PHV_WIDTH,
    parameter int HDR_BYTES            = depar_pkg::HDR_BYTES,
    parameter int DISCARD_BIT          = depar_pkg::DISCARD_BIT
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    pkt_fifo_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  pkt_fifo_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   pkt_fifo_tuser,
    input  logic                              pkt_fifo_tlast,
    input  logic                              pkt_fifo_empty,
    output logic                              pkt_fifo_rd_en,
    input  logic [PHV_WIDTH-1:0]              phv_fifo_out,
    input  logic                              phv_fifo_empty,
    output logic                              phv_fifo_rd_en,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready
`ifdef DEPAR_STATS_EN
    ,
    output logic [31:0]                       pkt_out_cnt,
    output logic [31:0]                       pkt_drop_cnt
`endif
);

    import depar_pkg::*;

    localparam int HDR_W = HDR_BYTES * 8;

    depar_state_e                     state_q, state_d;
    logic                             free_s;
    logic                             load_s;
    logic                             pkt_rd_s;
    logic                             phv_rd_s;
    logic                             drop_first_s;
    logic [C_S_AXIS_DATA_WIDTH-1:0]   ld_tdata_s;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]  ld_tuser_s;
    logic                             unused_phv_s;

    // Only the header slice, metadata and discard flag are consumed here
    assign unused_phv_s = ^phv_fifo_out;

    // Packet sequencing: pick the beat source, pops and next state
    always_comb begin
        state_d      = state_q;
        load_s       = 1'b0;
        pkt_rd_s     = 1'b0;
        phv_rd_s     = 1'b0;
        drop_first_s = 1'b0;
        ld_tdata_s   = pkt_fifo_tdata;
        ld_tuser_s   = pkt_fifo_tuser;
        if (reset) begin
            // Abandon any packet in flight; no pops while reset is held
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!pkt_fifo_empty && !phv_fifo_empty) begin
                        if (phv_fifo_out[DISCARD_BIT]) begin
                            pkt_rd_s     = 1'b1;
                            phv_rd_s     = 1'b1;
                            drop_first_s = 1'b1;
                            state_d      = pkt_fifo_tlast ? IDLE : DROP;
                        end else if (free_s) begin
                            load_s     = 1'b1;
                            pkt_rd_s   = 1'b1;
                            phv_rd_s   = 1'b1;
                            ld_tdata_s[HDR_W-1:0] = phv_fifo_out[PHV_WIDTH-1 -: HDR_W];
                            ld_tuser_s = phv_fifo_out[META_HI:META_LO];
                            state_d    = pkt_fifo_tlast ? IDLE : BODY;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                BODY: begin
                    if (free_s && !pkt_fifo_empty) begin
                        load_s   = 1'b1;
                        pkt_rd_s = 1'b1;
                        state_d  = pkt_fifo_tlast ? IDLE : BODY;
                    end else begin
                        state_d = BODY;
                    end
                end
                DROP: begin
                    if (!pkt_fifo_empty) begin
                        pkt_rd_s = 1'b1;
                        state_d  = pkt_fifo_tlast ? IDLE : DROP;
                    end else begin
                        state_d = DROP;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign pkt_fifo_rd_en = pkt_rd_s;
    assign phv_fifo_rd_en = phv_rd_s;

    depar_out_reg #(
        .DATA_W (C_S_AXIS_DATA_WIDTH),
        .USER_W (C_S_AXIS_TUSER_WIDTH)
    ) u_out_reg (
        .clk      (clk),
        .reset    (reset),
        .load_i   (load_s),
        .tdata_i  (ld_tdata_s),
        .tkeep_i  (pkt_fifo_tkeep),
        .tuser_i  (ld_tuser_s),
        .tlast_i  (pkt_fifo_tlast),
        .tready_i (m_axis_tready),
        .free_o   (free_s),
        .tdata_o  (m_axis_tdata),
        .tkeep_o  (m_axis_tkeep),
        .tuser_o  (m_axis_tuser),
        .tvalid_o (m_axis_tvalid),
        .tlast_o  (m_axis_tlast)
    );

`ifdef DEPAR_STATS_EN
    logic [31:0] out_cnt_q;
    logic [31:0] drop_cnt_q;

    // Delivered-packet counter: one per accepted last beat
    always_ff @(posedge clk) begin
        if (reset) begin
            out_cnt_q <= 32'd0;
        end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            out_cnt_q <= out_cnt_q + 32'd1;
        end else begin
            out_cnt_q <= out_cnt_q;
        end
    end

    // Dropped-packet counter: one per discarded first-beat pop
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= 32'd0;
        end else if (drop_first_s) begin
            drop_cnt_q <= drop_cnt_q + 32'd1;
        end else begin
            drop_cnt_q <= drop_cnt_q;
        end
    end

    assign pkt_out_cnt  = out_cnt_q;
    assign pkt_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_pkt_hdr_deparser.sv
// Self-checking bench for pkt_hdr_deparser: queue-based FIFO models feed the
// DUT, and a scoreboard of expected output beats (built from the packet and
// PHV at push time) is compared at every downstream handshake.
module tb_pkt_hdr_deparser;

    localparam int DW = 256;
    localparam int KW = 32;
    localparam int UW = 128;
    localparam int PW = 1124;
    localparam int HB = 32;
    localparam int DB = 128;

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [UW-1:0] u;
        logic          l;
        logic          first;
    } beat_t;

    logic          clk;
    logic          reset;
    logic [DW-1:0] pkt_fifo_tdata;
    logic [KW-1:0] pkt_fifo_tkeep;
    logic [UW-1:0] pkt_fifo_tuser;
    logic          pkt_fifo_tlast;
    logic          pkt_fifo_empty;
    logic          pkt_fifo_rd_en;
    logic [PW-1:0] phv_fifo_out;
    logic          phv_fifo_empty;
    logic          phv_fifo_rd_en;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic [UW-1:0] m_axis_tuser;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready;
`ifdef DEPAR_STATS_EN
    logic [31:0]   pkt_out_cnt;
    logic [31:0]   pkt_drop_cnt;
`endif

    pkt_hdr_deparser dut (
        .clk            (clk),
        .reset          (reset),
        .pkt_fifo_tdata (pkt_fifo_tdata),
        .pkt_fifo_tkeep (pkt_fifo_tkeep),
        .pkt_fifo_tuser (pkt_fifo_tuser),
        .pkt_fifo_tlast (pkt_fifo_tlast),
        .pkt_fifo_empty (pkt_fifo_empty),
        .pkt_fifo_rd_en (pkt_fifo_rd_en),
        .phv_fifo_out   (phv_fifo_out),
        .phv_fifo_empty (phv_fifo_empty),
        .phv_fifo_rd_en (phv_fifo_rd_en),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tkeep   (m_axis_tkeep),
        .m_axis_tuser   (m_axis_tuser),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tready  (m_axis_tready)
`ifdef DEPAR_STATS_EN
        ,
        .pkt_out_cnt    (pkt_out_cnt),
        .pkt_drop_cnt   (pkt_drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    beat_t         pkt_q[$];
    logic [PW-1:0] phv_q[$];
    beat_t         exp_q[$];
    logic [PW-1:0] held_phv;

    int  tests = 0;
    int  fails = 0;
    int  pkt_pops = 0;
    int  phv_pops = 0;
    int  valid_cycles = 0;
    int  out_pkts = 0;
    int  drop_pkts = 0;
    bit  rdy = 1'b1;
    bit  rnd_rdy = 1'b0;
    bit  prev_hold = 1'b0;
    beat_t prev_out;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic [UW-1:0] s_user;
    logic          s_last;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [PW-1:0] rand_phv();
        logic [1151:0] t;
        for (int w = 0; w < 1152; w += 32) t[w +: 32] = $urandom;
        return t[PW-1:0];
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] t;
        for (int w = 0; w < DW; w += 32) t[w +: 32] = $urandom;
        return t;
    endfunction

    // Build a packet + PHV, enqueue them, and record the expected output beats
    task automatic push_packet(input int n, input bit discard, input bit give_phv, input bit directed);
        logic [PW-1:0] phv;
        beat_t b;
        beat_t e;
        phv = rand_phv();
        if (directed) begin
            for (int i = 0; i < HB; i++) phv[PW - HB*8 + 8*i +: 8] = 8'h11 + 8'(i);
            phv[UW-1:0] = 128'd5;
        end
        phv[DB] = discard;
        for (int i = 0; i < n; i++) begin
            b.d     = directed ? {32{8'hAA}} : rand_data();
            b.k     = directed ? 32'hFFFF_FFFF : $urandom;
            b.u     = {$urandom, $urandom, $urandom, $urandom};
            b.l     = (i == n - 1);
            b.first = (i == 0);
            pkt_q.push_back(b);
            if (!discard) begin
                e = b;
                if (i == 0) begin
                    for (int j = 0; j < HB; j++) e.d[8*j +: 8] = phv[PW - HB*8 + 8*j +: 8];
                    e.u = phv[UW-1:0];
                end
                exp_q.push_back(e);
            end
        end
        if (discard) drop_pkts++;
        if (give_phv) phv_q.push_back(phv);
        else held_phv = phv;
    endtask

    // One clock: drive FIFO heads, sample/check outputs, then apply pops
    task automatic tick();
        bit    do_pkt;
        bit    do_phv;
        bit    head_first;
        beat_t got;
        beat_t ex;
        @(negedge clk);
        if (pkt_q.size() > 0) begin
            pkt_fifo_tdata = pkt_q[0].d;
            pkt_fifo_tkeep = pkt_q[0].k;
            pkt_fifo_tuser = pkt_q[0].u;
            pkt_fifo_tlast = pkt_q[0].l;
            head_first     = pkt_q[0].first;
        end else begin
            pkt_fifo_tdata = '0;
            pkt_fifo_tkeep = '0;
            pkt_fifo_tuser = '0;
            pkt_fifo_tlast = 1'b0;
            head_first     = 1'b0;
        end
        pkt_fifo_empty = (pkt_q.size() == 0);
        phv_fifo_out   = (phv_q.size() > 0) ? phv_q[0] : '0;
        phv_fifo_empty = (phv_q.size() == 0);
        m_axis_tready  = rnd_rdy ? ($urandom_range(0, 3) != 0) : rdy;
        #1;
        check("pkt_pop_when_empty", DW'(pkt_fifo_rd_en && pkt_fifo_empty), '0);
        check("phv_pop_not_first", DW'(phv_fifo_rd_en && !(pkt_fifo_rd_en && head_first)), '0);
        if (reset) check("pop_in_reset", DW'({pkt_fifo_rd_en, phv_fifo_rd_en}), '0);
        got.d = m_axis_tdata; got.k = m_axis_tkeep; got.u = m_axis_tuser; got.l = m_axis_tlast;
        got.first = 1'b0;
        if (prev_hold) begin
            check("hold_valid", DW'(m_axis_tvalid), DW'(1'b1));
            check("hold_data", got.d, prev_out.d);
            check("hold_user", DW'(got.u), DW'(prev_out.u));
            check("hold_keep_last", DW'({got.k, got.l}), DW'({prev_out.k, prev_out.l}));
        end
        if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", DW'(1'b1), DW'(1'b0));
            end else begin
                ex = exp_q.pop_front();
                check("out_data", got.d, ex.d);
                check("out_keep", DW'(got.k), DW'(ex.k));
                check("out_user", DW'(got.u), DW'(ex.u));
                check("out_last", DW'(got.l), DW'(ex.l));
                if (got.l) out_pkts++;
            end
        end
        if (m_axis_tvalid) valid_cycles++;
        s_valid = m_axis_tvalid; s_data = m_axis_tdata; s_user = m_axis_tuser; s_last = m_axis_tlast;
        prev_hold = m_axis_tvalid && !m_axis_tready;
        prev_out  = got;
        do_pkt = pkt_fifo_rd_en && !pkt_fifo_empty;
        do_phv = phv_fifo_rd_en && !phv_fifo_empty;
        @(posedge clk);
        if (do_pkt) begin void'(pkt_q.pop_front()); pkt_pops++; end
        if (do_phv) begin void'(phv_q.pop_front()); phv_pops++; end
    endtask

    initial begin
        int p0;
        int h0;
        int v0;
        int budget;
        logic [DW-1:0] hdr_exp;
        bit v[6];

        reset = 1'b1;
        // Reset with a packet already waiting: no pops, outputs cleared
        push_packet(1, 1'b0, 1'b1, 1'b1);
        tick(); tick(); tick();
        #1;
        check("rst_tvalid", DW'(m_axis_tvalid), '0);
        check("rst_tdata", m_axis_tdata, '0);
        check("rst_tuser_keep_last", DW'({m_axis_tuser, m_axis_tkeep, m_axis_tlast}), '0);
        check("rst_no_pops", DW'(pkt_pops + phv_pops), '0);
        reset = 1'b0;

        // Single-beat packet with header write-back
        for (int i = 0; i < HB; i++) hdr_exp[8*i +: 8] = 8'h11 + 8'(i);
        p0 = pkt_pops; h0 = phv_pops;
        tick();
        check("t1_latency_pre", DW'(s_valid), '0);
        tick();
        check("t1_valid", DW'(s_valid), DW'(1'b1));
        check("t1_hdr", s_data, hdr_exp);
        check("t1_tuser", DW'(s_user), DW'(128'd5));
        check("t1_tlast", DW'(s_last), DW'(1'b1));
        tick(); tick();
        check("t1_pkt_pops", DW'(pkt_pops - p0), DW'(1));
        check("t1_phv_pops", DW'(phv_pops - h0), DW'(1));

        // 3-beat packet under a 1,0,0 ready pattern
        push_packet(3, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            rdy = (i % 3 == 0);
            tick();
        end
        rdy = 1'b1;
        tick(); tick();
        check("t2_all_out", DW'(exp_q.size()), '0);

        // Discarded 4-beat packet
        p0 = pkt_pops; h0 = phv_pops; v0 = valid_cycles;
        push_packet(4, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) tick();
        check("t3_pkt_pops", DW'(pkt_pops - p0), DW'(4));
        check("t3_phv_pops", DW'(phv_pops - h0), DW'(1));
        check("t3_no_valid", DW'(valid_cycles - v0), '0);
`ifdef DEPAR_STATS_EN
        check("t3_drop_cnt", DW'(pkt_drop_cnt), DW'(1));
`endif

        // PHV arrives late
        p0 = pkt_pops; h0 = phv_pops; v0 = valid_cycles;
        push_packet(2, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        check("t4_no_pops", DW'((pkt_pops - p0) + (phv_pops - h0)), '0);
        check("t4_no_valid", DW'(valid_cycles - v0), '0);
        phv_q.push_back(held_phv);
        tick();
        check("t4_pre_valid", DW'(s_valid), '0);
        tick();
        check("t4_first_valid", DW'(s_valid), DW'(1'b1));
        tick(); tick();
        check("t4_drained", DW'(exp_q.size()), '0);

        // Two 2-beat packets back-to-back
        push_packet(2, 1'b0, 1'b1, 1'b0);
        push_packet(2, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            v[i] = s_valid;
        end
        check("t5_valid_run", DW'({v[0], v[1], v[2], v[3], v[4], v[5]}), DW'(6'b011110));

        // Reset during beat 2 of a 3-beat packet
        push_packet(3, 1'b0, 1'b1, 1'b0);
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pkt_q.delete(); phv_q.delete(); exp_q.delete();
        prev_hold = 1'b0; out_pkts = 0; drop_pkts = 0;
        tick();
        check("t6_valid_after_rst", DW'(s_valid), '0);
        push_packet(2, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        check("t6_next_pkt_out", DW'(exp_q.size()), '0);

        // Randomized traffic with random backpressure
        rnd_rdy = 1'b1;
        for (int i = 0; i < 30; i++)
            push_packet($urandom_range(1, 4), ($urandom_range(0, 3) == 0), 1'b1, 1'b0);
        budget = 0;
        while ((pkt_q.size() > 0 || exp_q.size() > 0) && budget < 3000) begin
            tick();
            budget++;
        end
        check("rand_timeout", DW'(budget >= 3000), '0);
        check("rand_all_out", DW'(exp_q.size()), '0);
        rnd_rdy = 1'b0;
        rdy = 1'b1;
        tick(); tick();
`ifdef DEPAR_STATS_EN
        check("stat_out_cnt", DW'(pkt_out_cnt), DW'(out_pkts));
        check("stat_drop_cnt", DW'(pkt_drop_cnt), DW'(drop_pkts));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
